// File: rtl/iq_free_list_if.sv
// Dispatch-side and issue-side signals of the issue-queue free list.
// The free list drives the master side; dispatch/issue logic sits on the slave side.
interface iq_free_list_if #(
  parameter int SIZE_ISSUEQ_LOG = 5,
  parameter int DISPATCH_WIDTH  = 4,
  parameter int ISSUE_WIDTH     = 5
);
  logic                                          flush_i;
  logic [SIZE_ISSUEQ_LOG:0]                      iqSize_i;
  logic                                          backEndReady_i;
  logic [ISSUE_WIDTH-1:0][SIZE_ISSUEQ_LOG:0]     freedEntry_i;
  logic [DISPATCH_WIDTH-1:0][SIZE_ISSUEQ_LOG:0]  freeEntry_o;
  logic                                          iqFull_o;
  logic [SIZE_ISSUEQ_LOG:0]                      freeCnt_o;
  logic                                          error_o;

  modport master (
    input  flush_i, iqSize_i, backEndReady_i, freedEntry_i,
    output freeEntry_o, iqFull_o, freeCnt_o, error_o
  );

  modport slave (
    output flush_i, iqSize_i, backEndReady_i, freedEntry_i,
    input  freeEntry_o, iqFull_o, freeCnt_o, error_o
  );
endinterface

// File: rtl/iq_free_list.sv
// Circular free list of issue-queue entry IDs: hands DISPATCH_WIDTH IDs to dispatch
// per bundle and reclaims IDs released at issue, over a dynamically sized active IQ.
module iq_free_list_chk (
  input logic clk,
  input logic reset,
  input logic flush,
  input logic overflow
);
  // More IDs returned than the active IQ holds means a duplicate or stray free upstream.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(overflow && !flush));
endmodule

module iq_free_list #(
  parameter int SIZE_ISSUEQ     = 32,
  parameter int SIZE_ISSUEQ_LOG = 5,
  parameter int DISPATCH_WIDTH  = 4,
  parameter int ISSUE_WIDTH     = 5
) (
  input logic            clk,
  input logic            reset,
  iq_free_list_if.master bus
);
  localparam int CW = SIZE_ISSUEQ_LOG + 1;

  typedef logic [SIZE_ISSUEQ_LOG-1:0] ptr_t;
  typedef logic [CW-1:0]              cnt_t;
  typedef logic [CW:0]                sum_t;

  ptr_t ids_r [SIZE_ISSUEQ];
  ptr_t head_r;
  ptr_t tail_r;
  cnt_t free_cnt_r;
  cnt_t iq_size_r;
  logic iq_full_r;
  logic error_r;

  logic alloc_s;
  logic alloc_blocked_s;
  logic overflow_s;
  ptr_t freed_id_s [ISSUE_WIDTH];
  cnt_t n_freed_s;
  sum_t sum_s;
  cnt_t next_cnt_s;
  int   pos_s;

  // Compact the valid freed lanes in ascending lane order so they land contiguously at tail.
  always_comb begin
    pos_s = 0;
    for (int j = 0; j < ISSUE_WIDTH; j++) begin
      freed_id_s[j] = '0;
    end
    for (int l = 0; l < ISSUE_WIDTH; l++) begin
      if (bus.freedEntry_i[l][SIZE_ISSUEQ_LOG]) begin
        for (int j = 0; j < ISSUE_WIDTH; j++) begin
          freed_id_s[j] = (j == pos_s) ? bus.freedEntry_i[l][SIZE_ISSUEQ_LOG-1:0] : freed_id_s[j];
        end
        pos_s = pos_s + 1;
      end else begin
        pos_s = pos_s;
      end
    end
    n_freed_s = cnt_t'(pos_s);
  end

  // Next free count; an alloc only happens with at least DISPATCH_WIDTH free, so no underflow.
  always_comb begin
    alloc_s         = bus.backEndReady_i & ~iq_full_r;
    alloc_blocked_s = bus.backEndReady_i & iq_full_r;
    sum_s           = {1'b0, free_cnt_r} + {1'b0, n_freed_s}
                      - (alloc_s ? sum_t'(DISPATCH_WIDTH) : sum_t'(0));
    overflow_s      = (sum_s > {1'b0, iq_size_r});
    if (overflow_s) begin
      next_cnt_s = iq_size_r;
    end else begin
      next_cnt_s = sum_s[CW-1:0];
    end
  end

  // Ring storage, pointers, count and sticky error; flush re-initialises all but the error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < SIZE_ISSUEQ; i++) begin
        ids_r[i] <= ptr_t'(i);
      end
      head_r     <= '0;
      tail_r     <= bus.iqSize_i[SIZE_ISSUEQ_LOG-1:0];
      free_cnt_r <= bus.iqSize_i;
      iq_size_r  <= bus.iqSize_i;
      iq_full_r  <= (bus.iqSize_i < cnt_t'(DISPATCH_WIDTH));
      error_r    <= 1'b0;
    end else if (bus.flush_i) begin
      for (int i = 0; i < SIZE_ISSUEQ; i++) begin
        ids_r[i] <= ptr_t'(i);
      end
      head_r     <= '0;
      tail_r     <= bus.iqSize_i[SIZE_ISSUEQ_LOG-1:0];
      free_cnt_r <= bus.iqSize_i;
      iq_size_r  <= bus.iqSize_i;
      iq_full_r  <= (bus.iqSize_i < cnt_t'(DISPATCH_WIDTH));
      error_r    <= error_r;
    end else begin
      for (int j = 0; j < ISSUE_WIDTH; j++) begin
        if (j < int'(n_freed_s)) begin
          ids_r[tail_r + ptr_t'(j)] <= freed_id_s[j];
        end
      end
      if (alloc_s) begin
        head_r <= head_r + ptr_t'(DISPATCH_WIDTH);
      end
      tail_r     <= tail_r + n_freed_s[SIZE_ISSUEQ_LOG-1:0];
      free_cnt_r <= next_cnt_s;
      iq_full_r  <= (next_cnt_s < cnt_t'(DISPATCH_WIDTH));
      if (overflow_s || alloc_blocked_s) begin
        error_r <= 1'b1;
      end
    end
  end

  // Offered entries come straight from the ring so dispatch sees them in the sampling cycle.
  always_comb begin
    for (int k = 0; k < DISPATCH_WIDTH; k++) begin
      bus.freeEntry_o[k] = {(free_cnt_r > cnt_t'(k)), ids_r[head_r + ptr_t'(k)]};
    end
  end

  assign bus.iqFull_o  = iq_full_r;
  assign bus.freeCnt_o = free_cnt_r;
  assign bus.error_o   = error_r;

  iq_free_list_chk u_chk (
    .clk      (clk),
    .reset    (reset),
    .flush    (bus.flush_i),
    .overflow (overflow_s)
  );
endmodule
